arb_requester: RTL and testbench
================================

ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter LEN_W, default 4: width of cmd_len; a burst is cmd_len+1 beats (1..2^LEN_W).
REQ-002 Parameter TIMEOUT, default 16: consecutive REQ-state cycles without gnt before abort; legal range 1..255.
REQ-003 Parameter GAP, default 2: minimum req-low cycles between bursts; legal range 1..255.
REQ-004 clock  in  1  clock; all state changes on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 cmd_valid  in  1  burst command offered.
REQ-007 cmd_len  in  LEN_W  beats minus one, sampled on acceptance.
REQ-008 cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid and cmd_ready both high at a clock edge.
REQ-009 req  out  1  active-high request to the grant arbiter.
REQ-010 gnt  in  1  active-high grant from the arbiter for this agent.
REQ-011 beat_valid  out  1  one transfer beat this cycle.
REQ-012 beat_idx  out  LEN_W  index of current beat, 0-based.
REQ-013 done  out  1  one-cycle pulse: burst completed.
REQ-014 timeout_err  out  1  one-cycle pulse: no grant within TIMEOUT.
REQ-015 lost_err  out  1  one-cycle pulse: gnt dropped mid-burst.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, REQ, XFER, RELEASE, GAP.
REQ-018 IDLE: on accepted command, latch cmd_len, clear beat counter and timer, go to REQ.
REQ-019 REQ: req=1; if gnt=1 go to XFER; else timer increments; when TIMEOUT gnt-less cycles are reached, go to RELEASE and pulse timeout_err in the first RELEASE cycle.
REQ-020 XFER: req=1; beat_valid=gnt (the only output combinationally dependent on an input); beat_idx=beat counter; counter increments on each beat.
REQ-021 XFER: beat with beat_idx equal to latched length -> RELEASE next edge, done pulses in first RELEASE cycle.
REQ-022 XFER: gnt=0 in any cycle -> no beat that cycle, go to RELEASE, lost_err pulses in first RELEASE cycle; beat_idx retains count of beats completed.
REQ-023 RELEASE: req=0; remain until gnt=0 is sampled (arbiter grant lags req by up to 2 cycles), then go to GAP with timer cleared.
REQ-024 GAP: req=0 for exactly GAP cycles, then IDLE; total req-low time between bursts is >= GAP+1 cycles.
REQ-025 gnt SHALL be ignored in IDLE and GAP; a stale gnt never produces beat_valid.
REQ-026 done, timeout_err, lost_err SHALL be mutually exclusive and each last exactly one cycle.
REQ-027 Timer and beat counter SHALL saturate, never wrap; beat counter width LEN_W, timer width 8.

Reset
REQ-028 With reset high at an edge: state=IDLE, counters=0; req, beat_valid, done, timeout_err, lost_err, busy = 0; beat_idx=0.
REQ-029 cmd_ready SHALL be 0 while reset is high.
REQ-030 Reset mid-burst SHALL drop req at the next edge without done or error pulse.

Structure
REQ-031 Package arb_pkg SHALL hold the 3-bit state encodings (IDLE=0, REQ=1, XFER=2, RELEASE=3, GAP=4), shared with the arbiter encoding width.
REQ-032 Sub-module arb_timer (loadable saturating 8-bit up-counter with clear, enable, and terminal-compare output) SHALL serve both the timeout and gap timing.

Verification
REQ-033 cmd_len=3, arbiter model grants 2 cycles after req -> 4 beat_valid cycles, beat_idx 0,1,2,3; done one cycle later; req low that cycle.
REQ-034 TIMEOUT=16, gnt held 0 -> req high exactly 16 cycles, timeout_err single pulse, cmd_ready returns after gnt-low + GAP cycles.
REQ-035 cmd_len=7, gnt drops after beat 2 -> 3 beats (idx 0..2), lost_err pulse, no done.
REQ-036 gnt held high 3 cycles after final beat -> stays in RELEASE, no beat_valid, cmd_ready low until gnt low plus GAP=2.
REQ-037 cmd_valid held high, cmd_len=0 -> back-to-back 1-beat bursts; req low >= GAP+1 cycles between bursts.
REQ-038 reset asserted in XFER beat 1 -> next edge req=0, all pulses 0, cmd_ready high after reset deasserts.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the burst requester: FSM state encoding and timer width.
// The 3-bit state width matches the arbiter's encoding so state can be traced side by side.
package arb_pkg;

    localparam int STATE_W = 3;
    localparam int TIMER_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_XFER    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4
    } arb_state_e;

endpackage

// File: rtl/arb_requester_if.sv
// Command, arbiter and beat signals of one requesting agent.
// master = the requester itself, slave = whoever issues commands and grants.
interface arb_requester_if #(
    parameter int LEN_W = 4
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             req;
    logic             gnt;
    logic             beat_valid;
    logic [LEN_W-1:0] beat_idx;
    logic             done;
    logic             timeout_err;
    logic             lost_err;
    logic             busy;

    modport master (
        input  cmd_valid, cmd_len, gnt,
        output cmd_ready, req, beat_valid, beat_idx, done, timeout_err, lost_err, busy
    );

    modport slave (
        output cmd_valid, cmd_len, gnt,
        input  cmd_ready, req, beat_valid, beat_idx, done, timeout_err, lost_err, busy
    );

endinterface

// File: rtl/arb_timer.sv
// Saturating 8-bit up-counter with clear, load and enable; tc_o flags count >= term_i.
// Shared by the request timeout and the inter-burst gap.
module arb_timer
    import arb_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               en_i,
    input  logic [TIMER_W-1:0] term_i,
    output logic               tc_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q >= term_i);

endmodule

// File: rtl/arb_requester.sv
// Burst requester: takes a command, requests the arbiter, streams len+1 beats while granted,
// then releases and holds req low for a minimum gap before accepting the next command.
module arb_requester
    import arb_pkg::*;
#(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16,
    parameter int GAP     = 2
) (
    input  logic            clock,
    input  logic            reset,
    arb_requester_if.master bus
);

    localparam logic [TIMER_W-1:0] TIMEOUT_TERM = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] GAP_TERM     = TIMER_W'(GAP - 1);

    arb_state_e         state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_cnt_q;
    logic               req_q;
    logic               cmd_ready_q;
    logic               busy_q;
    logic               done_q;
    logic               timeout_err_q;
    logic               lost_err_q;

    logic               accept;
    logic               timer_clr;
    logic               timer_en;
    logic               timer_tc;
    logic [TIMER_W-1:0] timer_term;

    assign accept = bus.cmd_valid && cmd_ready_q;

    // The timer counts gnt-less REQ cycles, then GAP cycles; IDLE and RELEASE hold it at zero.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
        timer_term = TIMEOUT_TERM;
        case (state_q)
            ST_IDLE, ST_RELEASE: timer_clr = 1'b1;
            ST_REQ:              timer_en  = !bus.gnt;
            ST_GAP: begin
                timer_en   = 1'b1;
                timer_term = GAP_TERM;
            end
            default: ;
        endcase
    end

    arb_timer u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (timer_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (timer_en),
        .term_i     (timer_term),
        .tc_o       (timer_tc)
    );

    always_ff @(posedge clock) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            beat_cnt_q    <= '0;
            req_q         <= 1'b0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            lost_err_q    <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            lost_err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_REQ;
                        len_q       <= bus.cmd_len;
                        beat_cnt_q  <= '0;
                        req_q       <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.gnt) begin
                        state_q <= ST_XFER;
                    end else if (timer_tc) begin
                        state_q       <= ST_RELEASE;
                        req_q         <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end
                end
                ST_XFER: begin
                    // Beat counter stops at the latched length, so it can never wrap.
                    if (!bus.gnt) begin
                        state_q    <= ST_RELEASE;
                        req_q      <= 1'b0;
                        lost_err_q <= 1'b1;
                    end else if (beat_cnt_q == len_q) begin
                        state_q <= ST_RELEASE;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!bus.gnt) begin
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (timer_tc) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_q       <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.req         = req_q;
    assign bus.beat_valid  = (state_q == ST_XFER) && bus.gnt;
    assign bus.beat_idx    = beat_cnt_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.lost_err    = lost_err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: each burst's cycle-by-cycle outputs are predicted from the command
// length and a scripted grant window, then compared every cycle.
module tb_arb_requester;

    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 16;
    localparam int GAP     = 2;

    logic clock = 1'b0;
    logic reset;

    int checks   = 0;
    int errors   = 0;
    int low_run  = 0;
    int last_gap = 0;

    arb_requester_if #(.LEN_W(LEN_W)) bus ();

    arb_requester #(
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef enum {OUT_DONE, OUT_LOST, OUT_TIMEOUT} outcome_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arbiter script: gnt is high for cycles [delay, delay+win) counted from the first REQ cycle.
    function automatic bit gnt_at(input int c, input int delay, input int win);
        return (c >= delay) && (c < delay + win);
    endfunction

    task automatic run_burst(input int len, input int delay, input int win, input bit hold,
                             input string name);
        int       nbeats;
        int       rel;
        int       e;
        int       r;
        int       wait_cyc;
        outcome_e oc;

        // Outcome of the burst from the grant window alone.
        if (delay < TIMEOUT) begin
            if (win - 1 >= len + 1) begin
                nbeats = len + 1;
                oc     = OUT_DONE;
                rel    = delay + 1 + nbeats;
            end else begin
                nbeats = win - 1;
                oc     = OUT_LOST;
                rel    = delay + 2 + nbeats;
            end
        end else begin
            nbeats = 0;
            oc     = OUT_TIMEOUT;
            rel    = TIMEOUT;
        end
        e = rel;
        while (gnt_at(e, delay, win)) e++;
        r = e + 1 + GAP;

        wait_cyc      = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_W'(len);
        #1;
        while (bus.cmd_ready !== 1'b1 && wait_cyc < 50) begin
            @(negedge clock);
            #1;
            wait_cyc++;
        end
        check($sformatf("%s.accept", name), 32'(bus.cmd_ready), 32'd1);
        if (bus.cmd_ready !== 1'b1) begin
            bus.cmd_valid = 1'b0;
            return;
        end

        for (int c = 0; c <= r; c++) begin
            bit bv_exp;
            @(negedge clock);
            if (!hold) bus.cmd_valid = 1'b0;
            bus.gnt = gnt_at(c, delay, win);
            #1;
            bv_exp = (c > delay) && (c <= delay + nbeats);
            check($sformatf("%s.req c=%0d", name, c), 32'(bus.req), 32'(c < rel));
            check($sformatf("%s.beat_valid c=%0d", name, c), 32'(bus.beat_valid), 32'(bv_exp));
            if (bv_exp)
                check($sformatf("%s.beat_idx c=%0d", name, c), 32'(bus.beat_idx), 32'(c - delay - 1));
            check($sformatf("%s.done c=%0d", name, c), 32'(bus.done),
                  32'((c == rel) && (oc == OUT_DONE)));
            check($sformatf("%s.timeout_err c=%0d", name, c), 32'(bus.timeout_err),
                  32'((c == rel) && (oc == OUT_TIMEOUT)));
            check($sformatf("%s.lost_err c=%0d", name, c), 32'(bus.lost_err),
                  32'((c == rel) && (oc == OUT_LOST)));
            check($sformatf("%s.busy c=%0d", name, c), 32'(bus.busy), 32'(c < r));
            check($sformatf("%s.cmd_ready c=%0d", name, c), 32'(bus.cmd_ready), 32'(c == r));
            if (bus.req === 1'b1) begin
                if (low_run > 0) last_gap = low_run;
                low_run = 0;
            end else begin
                low_run++;
            end
        end
        bus.gnt = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = '0;
        bus.gnt       = 1'b0;

        // Reset state, with a command offered that must not be seen as ready.
        repeat (3) @(negedge clock);
        #1;
        check("rst.req",         32'(bus.req),         32'd0);
        check("rst.beat_valid",  32'(bus.beat_valid),  32'd0);
        check("rst.beat_idx",    32'(bus.beat_idx),    32'd0);
        check("rst.done",        32'(bus.done),        32'd0);
        check("rst.timeout_err", 32'(bus.timeout_err), 32'd0);
        check("rst.lost_err",    32'(bus.lost_err),    32'd0);
        check("rst.busy",        32'(bus.busy),        32'd0);
        check("rst.cmd_ready",   32'(bus.cmd_ready),   32'd0);
        bus.cmd_valid = 1'b0;
        reset         = 1'b0;
        @(negedge clock);
        #1;
        check("post_rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("post_rst.busy",      32'(bus.busy),      32'd0);

        // Directed scenarios.
        run_burst(3, 2, 5, 1'b0, "len3_gnt_after2");
        run_burst(0, 100, 1, 1'b0, "timeout");
        run_burst(7, 2, 4, 1'b0, "lost_after_beat2");
        run_burst(3, 1, 8, 1'b0, "gnt_held_in_release");
        run_burst(2, 17, 2, 1'b0, "stale_gnt_in_gap");
        run_burst(0, 15, 3, 1'b0, "gnt_on_last_req_cycle");

        // Back-to-back single-beat bursts with cmd_valid held high.
        run_burst(0, 0, 2, 1'b1, "b2b0");
        run_burst(0, 0, 2, 1'b1, "b2b1");
        check("b2b.req_low_cycles", 32'(last_gap), 32'(GAP + 2));
        run_burst(0, 0, 2, 1'b0, "b2b2");
        check("b2b.req_low_cycles_2", 32'(last_gap), 32'(GAP + 2));

        // Randomised bursts, including grant windows that start after a timeout.
        for (int i = 0; i < 40; i++) begin
            run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 20)),
                      int'($urandom_range(1, 20)), (i < 39) ? bit'($urandom_range(0, 1)) : 1'b0,
                      $sformatf("rand%0d", i));
        end

        // Reset during the second beat of a burst.
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_W'(3);
        #1;
        check("mid_rst.ready_before", 32'(bus.cmd_ready), 32'd1);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        bus.gnt       = 1'b1;
        @(negedge clock);
        #1;
        check("mid_rst.beat0_valid", 32'(bus.beat_valid), 32'd1);
        check("mid_rst.beat0_idx",   32'(bus.beat_idx),   32'd0);
        @(negedge clock);
        #1;
        check("mid_rst.beat1_valid", 32'(bus.beat_valid), 32'd1);
        check("mid_rst.beat1_idx",   32'(bus.beat_idx),   32'd1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("mid_rst.req",         32'(bus.req),         32'd0);
        check("mid_rst.beat_valid",  32'(bus.beat_valid),  32'd0);
        check("mid_rst.done",        32'(bus.done),        32'd0);
        check("mid_rst.timeout_err", 32'(bus.timeout_err), 32'd0);
        check("mid_rst.lost_err",    32'(bus.lost_err),    32'd0);
        check("mid_rst.busy",        32'(bus.busy),        32'd0);
        check("mid_rst.cmd_ready",   32'(bus.cmd_ready),   32'd0);
        reset   = 1'b0;
        bus.gnt = 1'b0;
        @(negedge clock);
        #1;
        check("mid_rst.ready_after", 32'(bus.cmd_ready), 32'd1);
        check("mid_rst.done_after",  32'(bus.done),      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
